uart_rx_frame_ctrl: RTL and testbench

//  Sequences the byte stream from uart_rx into checked command frames: SOF, LEN, payload, CSUM.

---
 rtl/uart_rx_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_rx byte stream as SOF, LEN, payload, CSUM and releases the buffered
// payload on a valid/ready stream only once the 8-bit checksum of LEN..CSUM is zero.
module uart_rx_frame_ctrl #(
  parameter int          CLKS_PER_BIT = 10,
  parameter int          MAX_LEN      = 16,
  parameter int          TIMEOUT_BITS = 20,
  parameter logic [7:0]  SOF          = 8'h7E,
  localparam int         LW           = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_busy,
  output logic [7:0]    o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_last,
  output logic [LW-1:0] o_len,
  output logic          o_busy,
  output logic          o_err,
  output logic [1:0]    o_err_code
);

  localparam int TERM  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW    = $clog2(TERM + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] E_BADLEN  = 2'd0;
  localparam logic [1:0] E_CSUM    = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic [7:0]      r_sum;
  logic [LW-1:0]   r_wr_ptr;
  logic [LW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_len;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_last;
  logic            r_err;
  logic [1:0]      r_err_code;
  logic [7:0]      r_buf [0:DEPTH-1];

  logic [LW-1:0]   w_rd_next;
  logic [LW-1:0]   w_wr_next;
  logic [7:0]      w_csum;
  logic            w_tmo_term;
  logic            w_buf_we;

  assign w_rd_next  = r_rd_ptr + LW'(1);
  assign w_wr_next  = r_wr_ptr + LW'(1);
  assign w_csum     = r_sum + i_rx_data;
  assign w_tmo_term = (r_tmo == TW'(TERM - 1));
  assign w_buf_we   = (r_state == S_PAYLOAD) && i_rx_valid;

  // Payload store; contents need no reset since they are only read after being written.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_wr_ptr[AW-1:0]] <= i_rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_tmo      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && (i_rx_data == SOF)) begin
            r_state <= S_LEN;
            r_tmo   <= '0;
          end
        end

        S_LEN, S_PAYLOAD, S_CSUM: begin
          // A byte arriving on the terminal count cycle takes priority over the timeout.
          if (i_rx_valid) begin
            r_tmo <= '0;
            if (r_state == S_LEN) begin
              if ((i_rx_data == 8'h00) || (i_rx_data > 8'(MAX_LEN))) begin
                r_err      <= 1'b1;
                r_err_code <= E_BADLEN;
                r_state    <= S_IDLE;
              end else begin
                r_len    <= i_rx_data[LW-1:0];
                r_sum    <= i_rx_data;
                r_wr_ptr <= '0;
                r_state  <= S_PAYLOAD;
              end
            end else if (r_state == S_PAYLOAD) begin
              r_sum    <= r_sum + i_rx_data;
              r_wr_ptr <= w_wr_next;
              if (w_wr_next == r_len) begin
                r_state <= S_CSUM;
              end
            end else begin
              if (w_csum == 8'h00) begin
                r_rd_ptr <= '0;
                r_data   <= r_buf[0];
                r_valid  <= 1'b1;
                r_last   <= (r_len == LW'(1));
                r_state  <= S_DRAIN;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= E_CSUM;
                r_state    <= S_IDLE;
              end
            end
          end else if (!i_rx_busy) begin
            if (w_tmo_term) begin
              r_err      <= 1'b1;
              r_err_code <= E_TIMEOUT;
              r_tmo      <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end

        S_DRAIN: begin
          if (i_rx_valid) begin
            r_err      <= 1'b1;
            r_err_code <= E_OVERRUN;
          end
          if (r_valid && i_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_rd_ptr <= w_rd_next;
              r_data   <= r_buf[w_rd_next[AW-1:0]];
              r_last   <= (w_rd_next == (r_len - LW'(1)));
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_last     = r_last;
  assign o_len      = r_len;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus queues expected beats/errors derived
// from the frame rules; a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_rx_frame_ctrl;
  localparam int CPB  = 10;
  localparam int MAXL = 16;
  localparam int TOB  = 20;
  localparam int LW   = $clog2(MAXL + 1);
  localparam logic [7:0] SOFB = 8'h7E;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic          i_rx_busy = 1'b0;
  logic          i_ready = 1'b1;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          o_last;
  logic [LW-1:0] o_len;
  logic          o_busy;
  logic          o_err;
  logic [1:0]    o_err_code;

  uart_rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL), .TIMEOUT_BITS(TOB), .SOF(SOFB)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_rx_busy(i_rx_busy), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_len(o_len), .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
  } beat_t;

  beat_t      exp_q[$];
  int         err_q[$];
  logic [7:0] frm[$];
  int         tests = 0;
  int         fails = 0;
  bit         rdy_rand = 1'b0;
  bit         rdy_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_hold)      i_ready = 1'b0;
    else if (rdy_rand) i_ready = ($urandom_range(0, 3) != 0);
    else               i_ready = 1'b1;
  end

  // Monitor: every presented beat must be expected; transfers and error pulses pop the queues.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: got data 0x%0h, required no valid", o_data);
        end else if (i_ready) begin
          b = exp_q.pop_front();
          $display("[TB] beat data=0x%02h last=%0b len=%0d", o_data, o_last, o_len);
          chk("beat_data", o_data, b.data);
          chk("beat_last", o_last, b.last);
          chk("beat_len", o_len, b.len);
        end
      end
      if (o_err) begin
        $display("[TB] err code=%0d", o_err_code);
        if (err_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_err: got code %0d, required no error", o_err_code);
        end else begin
          chk("err_code", o_err_code, err_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic small_gap();
    int n;
    n = $urandom_range(0, 3);
    repeat (n) begin i_rx_busy = $urandom_range(0, 1); step(1); end
    i_rx_busy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 3000) begin step(1); n++; end
    if (o_busy) begin
      tests++; fails++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  // Reference: a frame is accepted iff 1<=L<=MAX and (L + payload + C) mod 256 == 0.
  task automatic send_frame(input bit do_wait);
    int         L;
    logic [7:0] s;
    L = frm[1];
    send_byte(frm[0]); small_gap();
    if (L == 0 || L > MAXL) begin
      err_q.push_back(0);
      send_byte(frm[1]); step(2);
      return;
    end
    send_byte(frm[1]); small_gap();
    s = 8'h00;
    for (int i = 1; i <= L + 2; i++) s = s + frm[i];
    for (int i = 0; i < L; i++) begin send_byte(frm[2 + i]); small_gap(); end
    if (s == 8'h00) begin
      for (int i = 0; i < L; i++) exp_q.push_back('{frm[2 + i], (i == L - 1), 8'(L)});
    end else begin
      err_q.push_back(1);
    end
    send_byte(frm[L + 2]);
    if (do_wait) wait_idle("frame_idle");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         L;
    logic [7:0] b;
    logic [7:0] s;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_len", o_len, 0);
    chk("rst_data", o_data, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(2);

    // 1: good three-byte frame
    frm = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(1);
    // 2: bad checksum
    frm = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_frame(1);
    chk("csum_err_idle", o_busy, 0);
    // 3: zero and oversize lengths, then a valid frame
    frm = '{8'h7E, 8'h00};
    send_frame(1);
    frm = '{8'h7E, 8'h11};
    send_frame(1);
    frm = '{8'h7E, 8'h01, 8'h5A, 8'hA5};
    send_frame(1);

    // 4: inter-byte timeout at exactly TOB*CPB cycles
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
    err_q.push_back(2);
    n = 0;
    while (!o_err && n < 400) begin step(1); n++; end
    chk("timeout_latency", n, TOB * CPB);
    step(1);
    chk("err_one_cycle", o_err, 0);
    chk("timeout_idle", o_busy, 0);
    // 4b: busy held high suspends the timeout
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
    i_rx_busy = 1'b1;
    step(300);
    i_rx_busy = 1'b0;
    chk("busy_no_timeout", o_busy, 1);
    send_byte(8'h55);
    exp_q.push_back('{8'hAA, 1'b0, 8'd2});
    exp_q.push_back('{8'h55, 1'b1, 8'd2});
    send_byte(8'hFF);
    wait_idle("busy_frame_idle");

    // 5: back-pressure plus overrun during DRAIN
    rdy_hold = 1'b1;
    step(1);
    frm = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_frame(0);
    step(2);
    err_q.push_back(3);
    send_byte(8'h55);
    step(2);
    chk("hold_valid", o_valid, 1);
    chk("hold_data", o_data, 8'h11);
    chk("hold_len", o_len, 3);
    rdy_hold = 1'b0;
    wait_idle("overrun_idle");

    // 6: leading junk, one-byte frame whose payload is SOF
    send_byte(8'h00); send_byte(8'hFF);
    chk("junk_ignored", o_busy, 0);
    frm = '{8'h7E, 8'h01, 8'h7E, 8'h81};
    send_frame(1);
    // 6b: asynchronous reset mid-payload
    send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    #2; rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_len", o_len, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_err", o_err, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    step(1);
    frm = '{8'h7E, 8'h02, 8'h10, 8'h20, 8'hCE};
    send_frame(1);

    // Randomized frames with random back-pressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        if (b == SOFB) b = 8'h00;
        send_byte(b);
      end
      if ($urandom_range(0, 9) < 8) L = $urandom_range(1, MAXL);
      else L = (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255));
      frm = {};
      frm.push_back(SOFB);
      frm.push_back(8'(L));
      if (L >= 1 && L <= MAXL) begin
        s = 8'(L);
        for (int i = 0; i < L; i++) begin
          b = 8'($urandom);
          frm.push_back(b);
          s = s + b;
        end
        b = 8'h00 - s;
        if ($urandom_range(0, 9) < 3) b = b ^ 8'($urandom_range(1, 255));
        frm.push_back(b);
      end
      send_frame(1);
    end
    rdy_rand = 1'b0;
    step(5);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
